// File: rtl/mac_seq_pkg.sv
// Shared types and sizing helpers for the sequential tiled multiply-accumulate.
package mac_seq_pkg;

   typedef enum logic [1:0] {
      DIS_E = 2'd0,
      ADD_E = 2'd1,
      SUB_E = 2'd2
   } mode_e_t;

   // Unsigned operand widths of one DSP multiplier (signed 27x18 primitive)
   localparam int unsigned DSP_A_U = 26;
   localparam int unsigned DSP_B_U = 17;

   function automatic int unsigned mac_seq_na(input int unsigned loga, input int unsigned logb);
      int unsigned w;
      w = (loga >= logb) ? loga : logb;
      return (w + DSP_A_U - 1) / DSP_A_U;
   endfunction

   function automatic int unsigned mac_seq_nb(input int unsigned loga, input int unsigned logb);
      int unsigned n;
      n = (loga >= logb) ? logb : loga;
      return (n + DSP_B_U - 1) / DSP_B_U;
   endfunction

   function automatic int unsigned mac_seq_logc(input int unsigned loga, input int unsigned logb,
                                                input int unsigned loge, input mode_e_t mode);
      int unsigned m;
      m = (loga + logb >= loge) ? loga + logb : loge;
      return (mode == DIS_E) ? loga + logb : m + 1;
   endfunction

   function automatic int unsigned mac_seq_ncyc(input int unsigned loga, input int unsigned logb,
                                                input int unsigned n_mul);
      int unsigned nt;
      nt = mac_seq_na(loga, logb) * mac_seq_nb(loga, logb);
      return (nt + n_mul - 1) / n_mul;
   endfunction

endpackage

// File: rtl/mac_seq_pp.sv
// Per-cycle partial products: N_MUL lanes each select one operand tile pair,
// multiply it on a DSP and align it to its weight in the result.
module mac_seq_pp
   import mac_seq_pkg::*;
#(
   parameter int unsigned LOGW  = 60,
   parameter int unsigned LOGN  = 60,
   parameter int unsigned LOGC  = 120,
   parameter int unsigned N_MUL = 1,
   parameter int unsigned CW    = 4
) (
   input  logic [LOGW-1:0]             a,
   input  logic [LOGN-1:0]             b,
   input  logic [CW-1:0]               cyc,
   output logic [N_MUL-1:0][LOGC-1:0]  pp
);

   localparam int unsigned N_A = mac_seq_na(LOGW, LOGN);
   localparam int unsigned N_B = mac_seq_nb(LOGW, LOGN);
   localparam int unsigned N_T = N_A * N_B;
   localparam int unsigned AW  = N_A * DSP_A_U;
   localparam int unsigned BW  = N_B * DSP_B_U;
   localparam int unsigned PW  = DSP_A_U + DSP_B_U;

   logic [AW-1:0] a_ext;
   logic [BW-1:0] b_ext;

   // Zero-pad so the narrower top tiles read as zero above the operand
   assign a_ext = AW'(a);
   assign b_ext = BW'(b);

   for (genvar l = 0; l < N_MUL; l++) begin : g_lane
      logic [31:0]          t;
      logic [31:0]          ti;
      logic [31:0]          tj;
      logic [DSP_A_U-1:0]   a_t;
      logic [DSP_B_U-1:0]   b_t;
      (* use_dsp = "yes" *) logic [PW-1:0] prod;
      logic [LOGC-1:0]      aligned;

      always_comb begin
         t       = 32'(cyc) * N_MUL + 32'(l);
         ti      = t / N_B;
         tj      = t % N_B;
         a_t     = DSP_A_U'(a_ext >> (ti * DSP_A_U));
         b_t     = DSP_B_U'(b_ext >> (tj * DSP_B_U));
         prod    = PW'(a_t) * PW'(b_t);
         aligned = '0;
         // Lanes past the last tile in the final cycle add nothing
         if (t < N_T) begin
            aligned = LOGC'(prod) << (ti * DSP_A_U + tj * DSP_B_U);
         end
      end

      assign pp[l] = aligned;
   end

endmodule

// File: rtl/mac_seq.sv
// Sequential multiply-accumulate: C = A*B (+/- E) computed tile by tile over
// NCYC cycles on N_MUL DSP multipliers, with valid/ready on both sides.
module mac_seq
   import mac_seq_pkg::*;
#(
   parameter int unsigned LOGA   = 60,
   parameter int unsigned LOGB   = 60,
   parameter mode_e_t     MODE_E = DIS_E,
   parameter int unsigned LOGE   = 32,
   parameter int unsigned N_MUL  = 1,
   localparam int unsigned LOGC  = mac_seq_logc(LOGA, LOGB, LOGE, MODE_E)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LOGA-1:0] A,
   input  logic [LOGB-1:0] B,
   input  logic [LOGE-1:0] E,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGC-1:0] C
);

   localparam int unsigned LOGW = (LOGA >= LOGB) ? LOGA : LOGB;
   localparam int unsigned LOGN = (LOGA >= LOGB) ? LOGB : LOGA;
   localparam int unsigned NCYC = mac_seq_ncyc(LOGA, LOGB, N_MUL);
   localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t                     state;
   state_t                     state_nx;
   logic                       accept;
   logic [LOGW-1:0]            w_op;
   logic [LOGN-1:0]            n_op;
   logic [LOGW-1:0]            a_q;
   logic [LOGN-1:0]            b_q;
   logic [LOGE-1:0]            e_q;
   logic [CW-1:0]              cnt;
   logic [LOGC-1:0]            acc;
   logic [LOGC-1:0]            pp_sum;
   logic [LOGC-1:0]            res;
   logic [N_MUL-1:0][LOGC-1:0] pp;

   // The wider operand is always tiled along the wide DSP port
   if (LOGA >= LOGB) begin : g_noswap
      assign w_op = A;
      assign n_op = B;
   end else begin : g_swap
      assign w_op = B;
      assign n_op = A;
   end

   mac_seq_pp #(
      .LOGW  (LOGW),
      .LOGN  (LOGN),
      .LOGC  (LOGC),
      .N_MUL (N_MUL),
      .CW    (CW)
   ) u_pp (
      .a   (a_q),
      .b   (b_q),
      .cyc (cnt),
      .pp  (pp)
   );

   always_comb begin
      pp_sum = '0;
      for (int l = 0; l < N_MUL; l++) begin
         pp_sum = pp_sum + pp[l];
      end
   end

   always_comb begin
      res = acc;
      case (MODE_E)
         ADD_E:   res = acc + LOGC'(e_q);
         SUB_E:   res = acc - LOGC'(e_q);
         default: res = acc;
      endcase
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept   = 1'b1;
               state_nx = MUL;
            end
         end
         MUL: begin
            if (cnt == CW'(NCYC - 1)) begin
               state_nx = FIN;
            end
         end
         FIN: state_nx = OUT;
         OUT: begin
            if (out_valid && out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         in_ready  <= (state_nx == IDLE);
         out_valid <= (state_nx == OUT);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= w_op;
         b_q <= n_op;
         e_q <= E;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
         C   <= '0;
      end else begin
         if (accept) begin
            cnt <= '0;
            acc <= '0;
         end else if (state == MUL) begin
            cnt <= cnt + CW'(1);
            acc <= acc + pp_sum;
         end
         if (state == FIN) begin
            C <= res;
         end
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
// Directed and streaming checks for mac_seq in DIS_E, ADD_E and SUB_E
// configurations (60x60 operands, 3x4 tiles).
module tb_mac_seq;
   import mac_seq_pkg::*;

   localparam int NU = 3;

   typedef struct {
      int           u;
      logic [59:0]  a;
      logic [59:0]  b;
      logic [31:0]  e;
      logic [120:0] c;
      int           lat;
   } vec_t;

   logic          clk;
   logic          rst;
   logic [NU-1:0] in_valid;
   logic [NU-1:0] in_ready;
   logic [NU-1:0] out_valid;
   logic [NU-1:0] out_ready;
   logic [59:0]   a_in [NU];
   logic [59:0]   b_in [NU];
   logic [31:0]   e_in [NU];
   logic [119:0]  c0;
   logic [120:0]  c1;
   logic [120:0]  c2;

   int            total;
   int            bad;
   int            lat;
   logic          seen;
   logic [59:0]   ones;
   logic [120:0]  sq;
   vec_t          vt [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mac_seq #(.LOGA(60), .LOGB(60), .MODE_E(DIS_E), .LOGE(32), .N_MUL(1)) u_dis (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .A(a_in[0]), .B(b_in[0]), .E(e_in[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .C(c0));

   mac_seq #(.LOGA(60), .LOGB(60), .MODE_E(ADD_E), .LOGE(32), .N_MUL(5)) u_add (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .A(a_in[1]), .B(b_in[1]), .E(e_in[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .C(c1));

   mac_seq #(.LOGA(60), .LOGB(60), .MODE_E(SUB_E), .LOGE(32), .N_MUL(12)) u_sub (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .A(a_in[2]), .B(b_in[2]), .E(e_in[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .C(c2));

   task automatic chk(input string nm, input logic [120:0] act, input logic [120:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [120:0] get_c(input int u);
      case (u)
         0:       return {1'b0, c0};
         1:       return c1;
         default: return c2;
      endcase
   endfunction

   function automatic logic [120:0] model(input int u, input logic [59:0] a, input logic [59:0] b,
                                          input logic [31:0] e);
      logic [127:0] p;
      p = 128'(a) * 128'(b);
      if (u == 0) return {1'b0, p[119:0]};
      if (u == 1) return 121'(p + 128'(e));
      return 121'(p - 128'(e));
   endfunction

   task automatic rnd(input int u);
      a_in[u] = 60'({$urandom(), $urandom()});
      b_in[u] = 60'({$urandom(), $urandom()});
      e_in[u] = $urandom();
      if ($urandom_range(0, 7) == 0) a_in[u] = '1;
      if ($urandom_range(0, 7) == 0) b_in[u] = '1;
   endtask

   task automatic run_op(input int u, input logic [59:0] a, input logic [59:0] b,
                         input logic [31:0] e, input logic [120:0] exp, input int lat_exp,
                         input string nm);
      int l;
      chk({nm, " in_ready"}, 121'(in_ready[u]), 121'(1));
      a_in[u] = a;
      b_in[u] = b;
      e_in[u] = e;
      in_valid[u] = 1'b1;
      @(negedge clk);
      in_valid[u] = 1'b0;
      l = 1;
      while (!out_valid[u] && l < 100) begin
         @(negedge clk);
         l++;
      end
      chk({nm, " latency"}, 121'(l), 121'(lat_exp));
      chk({nm, " C"}, get_c(u), exp);
      out_ready[u] = 1'b1;
      @(negedge clk);
      out_ready[u] = 1'b0;
      chk({nm, " back to idle"}, 121'(in_ready[u]), 121'(1));
   endtask

   task automatic stream(input int u, input int n, input int gap);
      logic [120:0] q [$];
      logic [120:0] exp;
      int sent, got, cyc, last;
      bit acc;
      sent = 0; got = 0; cyc = 0; last = -1; acc = 1'b0;
      rnd(u);
      in_valid[u]  = 1'b1;
      out_ready[u] = 1'b1;
      while (got < n && cyc < n * (gap + 2) + 50) begin
         if (out_valid[u]) begin
            if (q.size() > 0) exp = q.pop_front();
            else exp = ~get_c(u);
            chk($sformatf("stream u%0d result %0d", u, got), get_c(u), exp);
            if (last >= 0) chk($sformatf("stream u%0d spacing", u), 121'(cyc - last), 121'(gap));
            last = cyc;
            got++;
         end
         if (sent < n && in_ready[u]) begin
            q.push_back(model(u, a_in[u], b_in[u], e_in[u]));
            sent++;
            acc = 1'b1;
         end else if (sent >= n) begin
            in_valid[u] = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            rnd(u);
            acc = 1'b0;
         end
      end
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      chk($sformatf("stream u%0d count", u), 121'(got), 121'(n));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      in_valid = '0;
      out_ready = '0;
      for (int u = 0; u < NU; u++) begin
         a_in[u] = '0;
         b_in[u] = '0;
         e_in[u] = '0;
      end
      ones = '1;
      sq = (121'(1) << 120) - (121'(1) << 61) + 121'(1);

      repeat (3) @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         chk($sformatf("reset u%0d in_ready", u), 121'(in_ready[u]), 121'(1));
         chk($sformatf("reset u%0d out_valid", u), 121'(out_valid[u]), 121'(0));
         chk($sformatf("reset u%0d C", u), get_c(u), 121'(0));
      end
      rst = 1'b0;
      @(negedge clk);

      vt[0] = '{0, ones, ones, 32'd0, sq, 14};
      vt[1] = '{0, 60'd12345, 60'd678, 32'd0, 121'd8369910, 14};
      vt[2] = '{0, 60'h800000000000000, 60'd2, 32'd0, 121'h1000000000000000, 14};
      vt[3] = '{1, 60'd3, 60'd5, 32'd7, 121'd22, 5};
      vt[4] = '{1, ones, ones, 32'hFFFF_FFFF, sq + 121'(32'hFFFF_FFFF), 5};
      vt[5] = '{1, 60'd0, 60'd123456789, 32'd5, 121'd5, 5};
      vt[6] = '{2, 60'd1, 60'd1, 32'd2, {121{1'b1}}, 3};
      vt[7] = '{2, 60'd10, 60'd10, 32'd1, 121'd99, 3};
      vt[8] = '{2, 60'd0, 60'd0, 32'hFFFF_FFFF, 121'(0) - 121'(32'hFFFF_FFFF), 3};
      vt[9] = '{2, ones, ones, 32'd0, sq, 3};
      for (int k = 0; k < 10; k++) begin
         run_op(vt[k].u, vt[k].a, vt[k].b, vt[k].e, vt[k].c, vt[k].lat, $sformatf("vec%0d", k));
      end

      // Output back-pressure with a competing in_valid that must be ignored
      a_in[1] = 60'd3; b_in[1] = 60'd5; e_in[1] = 32'd7;
      in_valid[1] = 1'b1;
      @(negedge clk);
      a_in[1] = 60'd999; b_in[1] = 60'd999; e_in[1] = 32'd999;
      lat = 1;
      while (!out_valid[1] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("stall latency", 121'(lat), 121'(5));
      for (int k = 0; k < 10; k++) begin
         chk("stall C", get_c(1), 121'd22);
         chk("stall out_valid", 121'(out_valid[1]), 121'(1));
         chk("stall in_ready", 121'(in_ready[1]), 121'(0));
         @(negedge clk);
      end
      in_valid[1] = 1'b0;
      out_ready[1] = 1'b1;
      @(negedge clk);
      out_ready[1] = 1'b0;
      chk("stall release out_valid", 121'(out_valid[1]), 121'(0));
      chk("stall release in_ready", 121'(in_ready[1]), 121'(1));

      // Reset in the middle of MUL, with in_valid high during the reset cycle
      a_in[0] = 60'd12345; b_in[0] = 60'd77;
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      in_valid[0] = 1'b1;
      a_in[0] = 60'd7; b_in[0] = 60'd7;
      @(negedge clk);
      rst = 1'b0;
      in_valid[0] = 1'b0;
      chk("mid-rst in_ready", 121'(in_ready[0]), 121'(1));
      chk("mid-rst out_valid", 121'(out_valid[0]), 121'(0));
      chk("mid-rst C", get_c(0), 121'(0));
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid[0]) seen = 1'b1;
      end
      chk("mid-rst no output", 121'(seen), 121'(0));
      run_op(0, 60'd2, 60'd3, 32'd0, 121'd6, 14, "post-rst");

      stream(1, 1000, 6);
      stream(2, 200, 4);
      stream(0, 40, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
